vga_timing_controller: RTL and testbench

Generates 640x480@60 Hz VGA timing from the system clock and drives the ADV7123-style DAC pins. It presents active-area pixel coordinates and a pixel clock-enable to the upstream screen drawer. It captures the drawer's registered 24-bit colour and aligns it with delayed sync and blank so that every pixel reaches the pins with the correct timing. It is the stage directly downstream of the screen drawer and upstream of the board VGA connector.

---
 rtl/vga_timing_controller_if.sv | 32 +++
 rtl/vga_timing_controller.sv | 133 +++++++++++++
 tb/tb_vga_timing_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_controller_if.sv
// Drawer-facing and DAC-facing signals of the VGA timing controller.
// The master side is the controller; the slave side is the drawer plus board pins.
interface vga_timing_controller_if;
  logic        pix_ce;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_valid;
  logic        frame_start;
  logic [23:0] rgb_in;
  logic        vga_clk;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_sync_n;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  modport master (
    input  rgb_in,
    output pix_ce, pixel_x, pixel_y, pixel_valid, frame_start,
    output vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
    output vga_r, vga_g, vga_b
  );

  modport slave (
    output rgb_in,
    input  pix_ce, pixel_x, pixel_y, pixel_valid, frame_start,
    input  vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
    input  vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: pixel divider, h/v counters, sync/blank decode and
// a pix_ce-advanced alignment pipeline that lines sync/blank up with drawer colour.
module vga_timing_controller #(
  parameter int CLK_DIV    = 2,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int PIPE_DELAY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  vga_timing_controller_if.master  bus
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [H_W-1:0]   H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_SYNC_HI = H_W'(H_SYNC);
  localparam logic [H_W-1:0]   H_ACT_LO  = H_W'(H_SYNC + H_BACK);
  localparam logic [H_W-1:0]   H_ACT_HI  = H_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [V_W-1:0]   V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_SYNC_HI = V_W'(V_SYNC);
  localparam logic [V_W-1:0]   V_ACT_LO  = V_W'(V_SYNC + V_BACK);
  localparam logic [V_W-1:0]   V_ACT_HI  = V_W'(V_SYNC + V_BACK + V_ACTIVE);

  // Pipeline stage layout: {hs_n, vs_n, active}; idle value is syncs high, blanked.
  localparam logic [2:0] STAGE_IDLE = 3'b110;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic [2:0]       pipe_q [PIPE_DELAY];
  logic [2:0]       pipe_d [PIPE_DELAY];
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             vga_clk_q, vga_clk_d;

  logic             pix_ce;
  logic             hs_n, vs_n, h_act, v_act, pixel_valid;
  logic [2:0]       delayed;

  assign pix_ce      = (div_cnt_q == DIV_LAST);
  assign hs_n        = !(h_q < H_SYNC_HI);
  assign vs_n        = !(v_q < V_SYNC_HI);
  assign h_act       = (h_q >= H_ACT_LO) && (h_q < H_ACT_HI);
  assign v_act       = (v_q >= V_ACT_LO) && (v_q < V_ACT_HI);
  assign pixel_valid = h_act && v_act;
  assign delayed     = pipe_q[PIPE_DELAY-1];

  always_comb begin
    div_cnt_d = pix_ce ? '0 : div_cnt_q + DIV_W'(1);
    h_d       = h_q;
    v_d       = v_q;
    if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
  end

  always_comb begin
    pipe_d    = pipe_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (pix_ce) begin
      pipe_d[0] = {hs_n, vs_n, pixel_valid};
      for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
      hs_d      = delayed[2];
      vs_d      = delayed[1];
      blank_n_d = delayed[0];
      rgb_d     = delayed[0] ? bus.rgb_in : 24'h000000;
    end
    // DAC latches on the rising edge, placed mid-way through each output word.
    vga_clk_d = (div_cnt_d >= DIV_HALF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      h_q       <= '0;
      v_q       <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= STAGE_IDLE;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pipe_q    <= pipe_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  assign bus.pix_ce      = pix_ce;
  assign bus.pixel_valid = pixel_valid;
  assign bus.pixel_x     = pixel_valid ? 10'(h_q - H_ACT_LO) : 10'd0;
  assign bus.pixel_y     = pixel_valid ? 10'(v_q - V_ACT_LO) : 10'd0;
  assign bus.frame_start = pix_ce && (h_q == '0) && (v_q == '0);
  assign bus.vga_clk     = vga_clk_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_sync_n  = 1'b0;
  assign bus.vga_r       = rgb_q[23:16];
  assign bus.vga_g       = rgb_q[15:8];
  assign bus.vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: full-size 640x480 instance (CLK_DIV=2, PIPE_DELAY=1) and a
// shrunken-raster instance (CLK_DIV=4, PIPE_DELAY=2, 19x12 totals).
module tb_vga_timing_controller;
  localparam int PD_A = 1;
  localparam int PD_B = 2;

  logic clk     = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  logic white_b = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  vga_timing_controller_if if_a ();
  vga_timing_controller_if if_b ();

  vga_timing_controller #(.CLK_DIV(2), .PIPE_DELAY(PD_A)) u_a (
    .clk(clk), .reset(rst_a_n), .bus(if_a.master)
  );

  vga_timing_controller #(
    .CLK_DIV(4), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(5), .V_FRONT(2), .PIPE_DELAY(PD_B)
  ) u_b (
    .clk(clk), .reset(rst_b_n), .bus(if_b.master)
  );

  // Behavioural drawers: colour registered on pix_ce, PIPE_DELAY stages deep.
  logic [23:0] drw_a_q  = '0;
  logic [23:0] drw_b0_q = '0;
  logic [23:0] drw_b1_q = '0;
  always_ff @(posedge clk) if (if_a.pix_ce) drw_a_q <= {if_a.pixel_x[7:0], if_a.pixel_y[7:0], 8'hA5};
  always_ff @(posedge clk) begin
    if (if_b.pix_ce) begin
      drw_b0_q <= {if_b.pixel_x[7:0], if_b.pixel_y[7:0], 8'hA5};
      drw_b1_q <= drw_b0_q;
    end
  end
  assign if_a.rgb_in = drw_a_q;
  assign if_b.rgb_in = white_b ? 24'hFFFFFF : drw_b1_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          ta, tb, co, since, rises, vclk_bad, sync_bad, blank_bad;
  int          hs_low_a, blank_hi_a, align_bad_a;
  int          hs_low_b, vs_low_b, blank_hi_b, align_bad_b, white_ok_b, nvalid_b;
  int          first_ce_b, nfs, restart_blank;
  int          fs_clk [3];
  logic        prev_ce, prev_vclk, stop_b;
  logic [7:0]  ex_r, ex_g;
  logic [9:0]  maxx_b, maxy_b;
  logic [31:0] pres_a, first_vis_a, blank_at_pres_a, valid_before_a;
  logic [31:0] first_vis_b, pres_b, first_fs_b, first_pres_b, hs_vs_r0;

  initial begin
    hs_low_a = 0; blank_hi_a = 0; align_bad_a = 0;
    hs_low_b = 0; vs_low_b = 0; blank_hi_b = 0; align_bad_b = 0; white_ok_b = 0; nvalid_b = 0;
    rises = 0; vclk_bad = 0; sync_bad = 0; blank_bad = 0; nfs = 0; restart_blank = 0;
    fs_clk = '{0, 0, 0};
    maxx_b = '0; maxy_b = '0; stop_b = 1'b0;
    pres_a = '1; first_vis_a = '1; blank_at_pres_a = '1; valid_before_a = '1;
    first_vis_b = '1; pres_b = '1; first_fs_b = '1; first_pres_b = '1; hs_vs_r0 = '1;

    // ---------------- reset values, full-size instance
    repeat (10) @(negedge clk);
    check("rst_pix_ce",  if_a.pix_ce, 0);
    check("rst_fs",      if_a.frame_start, 0);
    check("rst_hs",      if_a.vga_hs, 1);
    check("rst_vs",      if_a.vga_vs, 1);
    check("rst_blank_n", if_a.vga_blank_n, 0);
    check("rst_rgb",     {if_a.vga_r, if_a.vga_g, if_a.vga_b}, 0);
    check("rst_vga_clk", if_a.vga_clk, 0);
    check("rst_sync_n",  if_a.vga_sync_n, 0);
    check("rst_valid",   if_a.pixel_valid, 0);
    check("rst_xy",      {if_a.pixel_x, if_a.pixel_y}, 0);
    rst_a_n = 1'b1;
    #1 check("ce_before_first_edge", if_a.pix_ce, 0);
    @(posedge clk); #1;
    check("first_ce", if_a.pix_ce, 1);
    check("first_fs", if_a.frame_start, 1);

    // ---------------- line timing, first visible pixel and alignment
    ta = 0;
    prev_ce = if_a.pix_ce;
    for (int c = 0; c < 60000 && ta < 28802; c++) begin
      @(posedge clk); #1;
      if (prev_ce) begin
        co = ta - PD_A;
        if (ta < 2400 && !if_a.vga_hs) hs_low_a++;
        if (co >= 28000 && co < 28800 && if_a.vga_blank_n) blank_hi_a++;
        if (if_a.vga_blank_n) begin
          ex_r = 8'((co % 800) - 144);
          ex_g = 8'((co / 800) - 35);
          if ({if_a.vga_r, if_a.vga_g, if_a.vga_b} !== {ex_r, ex_g, 8'hA5}) align_bad_a++;
        end
        if (ta == 28144) blank_at_pres_a = 32'(if_a.vga_blank_n);
        if (ta == 28145) first_vis_a = {7'd0, if_a.vga_blank_n, if_a.vga_r, if_a.vga_g, if_a.vga_b};
        ta++;
      end
      if (if_a.pix_ce) begin
        if (ta == 28143) valid_before_a = 32'(if_a.pixel_valid);
        if (ta == 28144) pres_a = {11'd0, if_a.pixel_valid, if_a.pixel_x, if_a.pixel_y};
      end
      prev_ce = if_a.pix_ce;
    end
    check("a_tick_budget",     ta, 28802);
    check("a_hs_low_3lines",   hs_low_a, 288);
    check("a_blank_hi_line35", blank_hi_a, 640);
    check("a_align_errors",    align_bad_a, 0);
    check("a_valid_before",    valid_before_a, 0);
    check("a_present_144_35",  pres_a, 32'h0010_0000);
    check("a_blank_n_tick1",   blank_at_pres_a, 0);
    check("a_first_visible",   first_vis_a, 32'h0100_00A5);

    // ---------------- small raster, CLK_DIV=4: two frames plus blank forcing
    @(negedge clk);
    rst_b_n = 1'b1;
    tb = 0; since = 0; prev_ce = 1'b0; prev_vclk = if_b.vga_clk; first_ce_b = -1;
    for (int c = 1; c <= 3000 && !stop_b; c++) begin
      @(posedge clk); #1;
      if (prev_ce) begin
        co = tb - PD_B;
        since = 0;
        if (co >= 0 && co < 456) begin
          if (!if_b.vga_hs) hs_low_b++;
          if (!if_b.vga_vs) vs_low_b++;
          if (if_b.vga_blank_n) blank_hi_b++;
        end
        if (if_b.vga_blank_n && co < 200) begin
          ex_r = 8'((co % 19) - 7);
          ex_g = 8'(((co / 19) % 12) - 5);
          if ({if_b.vga_r, if_b.vga_g, if_b.vga_b} !== {ex_r, ex_g, 8'hA5}) align_bad_b++;
        end
        if (if_b.vga_blank_n && co >= 228 && co < 456 &&
            {if_b.vga_r, if_b.vga_g, if_b.vga_b} == 24'hFFFFFF) white_ok_b++;
        if (!if_b.vga_blank_n && {if_b.vga_r, if_b.vga_g, if_b.vga_b} != 24'h0) blank_bad++;
        if (co == 102) first_vis_b = {7'd0, if_b.vga_blank_n, if_b.vga_r, if_b.vga_g, if_b.vga_b};
        tb++;
      end else begin
        since++;
      end
      if (if_b.vga_clk && !prev_vclk) begin
        rises++;
        if (since != 2) vclk_bad++;
      end
      prev_vclk = if_b.vga_clk;
      if (if_b.vga_sync_n !== 1'b0) sync_bad++;
      if (if_b.pix_ce) begin
        if (first_ce_b < 0) begin
          first_ce_b = c;
          first_fs_b = 32'(if_b.frame_start);
        end
        if (if_b.frame_start && nfs < 3) begin
          fs_clk[nfs] = c;
          nfs++;
        end
        if (tb < 456 && if_b.pixel_valid) begin
          nvalid_b++;
          if (if_b.pixel_x > maxx_b) maxx_b = if_b.pixel_x;
          if (if_b.pixel_y > maxy_b) maxy_b = if_b.pixel_y;
        end
        if (tb == 582) begin
          stop_b = 1'b1;
          pres_b = {11'd0, if_b.pixel_valid, if_b.pixel_x, if_b.pixel_y};
        end
      end
      white_b = (tb >= 200);
      prev_ce = if_b.pix_ce;
    end
    check("b_reached_mid_frame", 32'(stop_b), 1);
    check("b_first_ce_edge",     first_ce_b, 3);
    check("b_first_fs",          first_fs_b, 1);
    check("b_fs_period_0",       fs_clk[1] - fs_clk[0], 912);
    check("b_fs_period_1",       fs_clk[2] - fs_clk[1], 912);
    check("b_hs_low_2frames",    hs_low_b, 96);
    check("b_vs_low_2frames",    vs_low_b, 76);
    check("b_blank_hi_2frames",  blank_hi_b, 100);
    check("b_valid_presented",   nvalid_b, 100);
    check("b_max_x",             maxx_b, 9);
    check("b_max_y",             maxy_b, 4);
    check("b_align_errors",      align_bad_b, 0);
    check("b_first_visible",     first_vis_b, 32'h0100_00A5);
    check("b_white_visible",     white_ok_b, 50);
    check("b_rgb_in_blanking",   blank_bad, 0);
    check("b_sync_n_nonzero",    sync_bad, 0);
    check("b_vga_clk_rises",     rises, 583);
    check("b_vga_clk_phase",     vclk_bad, 0);
    check("b_present_12_6",      pres_b, 32'h0010_1401);

    // ---------------- asynchronous reset mid-frame
    #1 rst_b_n = 1'b0;
    #1;
    check("mr_pix_ce",  if_b.pix_ce, 0);
    check("mr_fs",      if_b.frame_start, 0);
    check("mr_valid",   {if_b.pixel_valid, if_b.pixel_x, if_b.pixel_y}, 0);
    check("mr_hs_vs",   {if_b.vga_hs, if_b.vga_vs}, 2'b11);
    check("mr_blank_n", if_b.vga_blank_n, 0);
    check("mr_rgb",     {if_b.vga_r, if_b.vga_g, if_b.vga_b}, 0);
    check("mr_vga_clk", if_b.vga_clk, 0);
    repeat (3) @(negedge clk);
    rst_b_n = 1'b1;
    tb = 0; prev_ce = 1'b0; first_ce_b = -1;
    for (int c = 1; c <= 600 && tb < 100; c++) begin
      @(posedge clk); #1;
      if (prev_ce) begin
        co = tb - PD_B;
        if (if_b.vga_blank_n) restart_blank++;
        if (co == 0) hs_vs_r0 = {30'd0, if_b.vga_hs, if_b.vga_vs};
        tb++;
      end
      if (if_b.pix_ce && first_ce_b < 0) begin
        first_ce_b = c;
        first_pres_b = {10'd0, if_b.frame_start, if_b.pixel_valid, if_b.pixel_x, if_b.pixel_y};
      end
      prev_ce = if_b.pix_ce;
    end
    check("rs_first_ce_edge",  first_ce_b, 3);
    check("rs_first_present",  first_pres_b, 32'h0020_0000);
    check("rs_no_partial",     restart_blank, 0);
    check("rs_sync_at_origin", hs_vs_r0, 0);
    check("rs_tick_budget",    tb, 100);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
